// File: rtl/sha256_msg_padder.sv
// Purpose : SHA-256 message padder. It packs a byte stream into 512-bit chunks and appends 0x80, zero fill and the 64-bit bit length.
// Latency : a chunk is valid 1 cycle after byte 64 is accepted, and 2 cycles after the last beat (PAD takes 1 cycle).
// Backpr. : the chunk is held stable until chunk_valid & chunk_ready; in_ready stays low for the whole time a chunk is pending.
//
// Ports:
//   clk, reset                       rising-edge clock, synchronous active-high reset
//   in_valid/in_data/in_keep/in_last byte stream in; in_ready is high only in FILL
//   chunk/chunk_valid/chunk_ready    512-bit chunk out; the first byte is in [511:504]
//   chunk_last                       marks the final chunk of a message
//   busy                             a message is in progress

module sha256_msg_padder #(
    parameter int CNT_W = 61
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [7:0]   in_data,
    input  logic         in_keep,
    input  logic         in_last,
    output logic         in_ready,
    output logic [511:0] chunk,
    output logic         chunk_valid,
    input  logic         chunk_ready,
    output logic         chunk_last,
    output logic         busy
);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        PAD   = 2'd1,
        EXTRA = 2'd2,
        SEND  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [511:0]       data_q;
    logic [6:0]         ptr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               pad_pending_q;   // message ended exactly on a chunk boundary
    logic               extra_pending_q; // length field did not fit; a length-only chunk follows
    logic               last_q;
    logic               busy_q;
    logic               accept;
    logic               xfer;
    logic [63:0]        len_bits;

    assign accept   = in_valid & in_ready;
    assign xfer     = chunk_valid & chunk_ready;
    assign len_bits = 64'({cnt_q, 3'b000});

    assign in_ready    = (state_q == FILL) & ~reset;
    assign chunk_valid = (state_q == SEND) & ~reset;
    assign chunk_last  = last_q & (state_q == SEND) & ~reset;
    assign busy        = busy_q & ~reset;
    assign chunk       = reset ? 512'd0 : data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL: begin
                if (accept) begin
                    if (in_keep && ptr_q == 7'd63) begin
                        state_d = SEND;
                    end else if (in_last) begin
                        state_d = PAD;
                    end
                end
            end
            PAD:   state_d = SEND;
            EXTRA: state_d = SEND;
            SEND: begin
                if (chunk_ready) begin
                    if (last_q) begin
                        state_d = FILL;
                    end else if (pad_pending_q) begin
                        state_d = PAD;
                    end else if (extra_pending_q) begin
                        state_d = EXTRA;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q          <= '0;
            ptr_q           <= '0;
            cnt_q           <= '0;
            pad_pending_q   <= 1'b0;
            extra_pending_q <= 1'b0;
            last_q          <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    if (accept && in_keep) begin
                        for (int i = 0; i < 64; i++) begin
                            if (ptr_q == 7'(i)) begin
                                data_q[511-8*i -: 8] <= in_data;
                            end
                        end
                        ptr_q  <= ptr_q + 7'd1;
                        cnt_q  <= cnt_q + 1'b1;
                        busy_q <= 1'b1;
                        if (ptr_q == 7'd63) begin
                            last_q        <= 1'b0;
                            pad_pending_q <= in_last;
                        end
                    end else if (accept && in_last) begin
                        busy_q <= 1'b1;
                    end
                    // in_keep=0 without in_last: the beat is consumed and has no effect
                end
                PAD: begin
                    for (int i = 0; i < 64; i++) begin
                        if (ptr_q == 7'(i)) begin
                            data_q[511-8*i -: 8] <= 8'h80;
                        end else if (7'(i) > ptr_q) begin
                            data_q[511-8*i -: 8] <= 8'h00;
                        end
                    end
                    pad_pending_q <= 1'b0;
                    if (ptr_q <= 7'd55) begin
                        // This write comes after the zero fill above, so the length field wins
                        data_q[63:0] <= len_bits;
                        last_q       <= 1'b1;
                    end else begin
                        last_q          <= 1'b0;
                        extra_pending_q <= 1'b1;
                    end
                end
                EXTRA: begin
                    data_q          <= {448'd0, len_bits};
                    last_q          <= 1'b1;
                    extra_pending_q <= 1'b0;
                end
                SEND: begin
                    if (chunk_ready) begin
                        data_q <= '0;
                        ptr_q  <= '0;
                        if (last_q) begin
                            cnt_q           <= '0;
                            busy_q          <= 1'b0;
                            last_q          <= 1'b0;
                            pad_pending_q   <= 1'b0;
                            extra_pending_q <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Purpose : directed bench for sha256_msg_padder. A standard SHA-256 padding model fills a scoreboard queue.
// Latency : a monitor pops expected chunks when transfers happen; every wait is bounded by a cycle budget.
// Backpr. : chunk_ready is driven from the stimulus sequence and held low for stall windows.

module tb_sha256_msg_padder;

    typedef struct packed {
        logic [511:0] d;
        logic         l;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic [7:0]   in_data;
    logic         in_keep;
    logic         in_last;
    logic         in_ready;
    logic [511:0] chunk;
    logic         chunk_valid;
    logic         chunk_ready;
    logic         chunk_last;
    logic         busy;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_xfer   = 0;

    sha256_msg_padder #(.CNT_W(61)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_keep     (in_keep),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .chunk       (chunk),
        .chunk_valid (chunk_valid),
        .chunk_ready (chunk_ready),
        .chunk_last  (chunk_last),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h required %h", tag, obs, exp);
    endtask

    // Standard SHA-256 padding of bytes first, first+1, ... (len of them)
    task automatic push_expected(input int len, input logic [7:0] first);
        int           tot;
        logic [7:0]   p[];
        logic [63:0]  bl;
        exp_t         e;
        tot = ((len + 9 + 63) / 64) * 64;
        p = new[tot];
        for (int i = 0; i < tot; i++) begin
            if (i < len)       p[i] = 8'(int'(first) + i);
            else if (i == len) p[i] = 8'h80;
            else               p[i] = 8'h00;
        end
        bl = 64'(len) * 64'd8;
        for (int k = 0; k < 8; k++) p[tot-8+k] = bl[63-8*k -: 8];
        for (int c = 0; c < tot / 64; c++) begin
            e.d = '0;
            for (int b = 0; b < 64; b++) e.d[511-8*b -: 8] = p[64*c+b];
            e.l = (c == tot / 64 - 1);
            sb.push_back(e);
        end
    endtask

    // Call this #1 after a rising edge. It returns #1 after the edge that accepted the beat.
    task automatic send_beat(input logic [7:0] d, input logic k, input logic l);
        logic acc;
        int   n;
        in_valid = 1'b1; in_data = d; in_keep = k; in_last = l;
        n = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            n++;
        end while (!acc && n < 200);
        in_valid = 1'b0; in_keep = 1'b0; in_last = 1'b0;
        if (!acc) check("beat_accept_timeout", 512'(acc), 512'(1));
    endtask

    task automatic send_msg(input int len, input logic [7:0] first, input int err_at);
        push_expected(len, first);
        if (len == 0) begin
            send_beat(8'h00, 1'b0, 1'b1);
        end else begin
            for (int i = 0; i < len; i++) begin
                if (i == err_at) send_beat(8'hFF, 1'b0, 1'b0);
                send_beat(8'(int'(first) + i), 1'b1, i == len - 1);
            end
        end
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while ((sb.size() != 0 || chunk_valid) && n < 500);
        check(tag, 512'(sb.size() == 0 && !chunk_valid), 512'(1));
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!chunk_valid && n < 500);
        check(tag, 512'(chunk_valid), 512'(1));
    endtask

    // Scoreboard monitor: every transfer must match the next expected chunk
    always @(negedge clk) begin
        if (!reset && chunk_valid && chunk_ready) begin
            n_xfer++;
            if (sb.size() == 0) begin
                check("unexpected_chunk", 512'(1), 512'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("chunk_data", chunk, e.d);
                check("chunk_last", 512'(chunk_last), 512'(e.l));
            end
        end
    end

    initial begin : stim
        logic         stable;
        logic [511:0] cap_d;
        logic         cap_l;
        int           x0;

        reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_keep = 1'b0; in_last = 1'b0;
        chunk_ready = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_in_ready", 512'(in_ready), 512'(0));
        check("rst_chunk_valid", 512'(chunk_valid), 512'(0));
        check("rst_chunk_last", 512'(chunk_last), 512'(0));
        check("rst_busy", 512'(busy), 512'(0));
        check("rst_chunk", chunk, 512'(0));
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("idle_in_ready", 512'(in_ready), 512'(1));
        check("idle_busy", 512'(busy), 512'(0));
        @(posedge clk); #1;

        // Test 1: "abc"
        send_msg(3, 8'h61, -1);
        check("abc_busy", 512'(busy), 512'(1));
        @(negedge clk);
        check("abc_pad_cycle_no_valid", 512'(chunk_valid), 512'(0));
        @(negedge clk);
        check("abc_valid_two_after_last", 512'(chunk_valid), 512'(1));
        wait_done("abc_done");
        check("abc_busy_clear", 512'(busy), 512'(0));
        @(posedge clk); #1;

        // Test 2: empty message
        send_msg(0, 8'h00, -1);
        wait_done("empty_done");
        @(posedge clk); #1;

        // Test 3: 56 bytes, so the length field moves into a second chunk
        send_msg(56, 8'h00, -1);
        wait_done("len56_done");
        @(posedge clk); #1;

        // Test 4: 64 bytes, with one ignored protocol-error beat in the middle
        send_msg(64, 8'h40, 20);
        check("len64_in_ready_low", 512'(in_ready), 512'(0));
        stable = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (in_ready !== 1'b0) stable = 1'b0;
        end
        check("len64_in_ready_held_low", 512'(stable), 512'(1));
        wait_done("len64_done");
        @(posedge clk); #1;

        // Test 5: test 3 again with 20-cycle stalls on each chunk
        x0 = n_xfer;
        chunk_ready = 1'b0;
        send_msg(56, 8'h00, -1);
        for (int c = 0; c < 2; c++) begin
            wait_valid("bp_wait_valid");
            cap_d = chunk; cap_l = chunk_last;
            stable = 1'b1;
            repeat (20) begin
                @(negedge clk);
                if (chunk !== cap_d || chunk_last !== cap_l || in_ready !== 1'b0 || chunk_valid !== 1'b1)
                    stable = 1'b0;
            end
            check("bp_stable", 512'(stable), 512'(1));
            @(posedge clk); #1 chunk_ready = 1'b1;
            @(posedge clk); #1 chunk_ready = 1'b0;
        end
        chunk_ready = 1'b1;
        wait_done("bp_done");
        check("bp_xfer_count", 512'(n_xfer - x0), 512'(2));
        @(posedge clk); #1;

        // Test 6: reset partway through a message, then "abc"
        for (int i = 0; i < 10; i++) send_beat(8'(i + 8'hA0), 1'b1, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", 512'(in_ready), 512'(0));
        check("midrst_busy", 512'(busy), 512'(0));
        check("midrst_chunk", chunk, 512'(0));
        @(posedge clk); #1 reset = 1'b0;
        x0 = n_xfer;
        stable = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (chunk_valid !== 1'b0) stable = 1'b0;
        end
        check("midrst_no_valid", 512'(stable), 512'(1));
        @(posedge clk); #1;
        send_msg(3, 8'h61, -1);
        wait_done("midrst_abc_done");
        check("midrst_xfer_count", 512'(n_xfer - x0), 512'(1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
